framestart_monitor: RTL and testbench
=====================================

// Module: framestart_monitor
// PURPOSE
// - Consumes the radar/camera/IR framestart pulses from the framestart generator (same clk domain).
// - Per channel, measures the rising-edge-to-rising-edge period, the high width and the frame count.
// - Checks each measurement against configured windows and raises sticky error flags.
// - Measures radar-to-camera trigger skew; all results go to PS-readable status registers.
// PARAMETERS
// - NUM_CH    3   number of monitored framestart channels; ch0 = radar, ch1 = camera, ch2 = IR
// - PER_W     32  period/timeout counter width, in clk cycles
// - WID_W     16  high-width counter width, in clk cycles
// PORTS
// - clk               in   1            system clock (200 MHz)
// - rst_n             in   1            reset, asynchronous, active-low
// - i_fs              in   NUM_CH       framestart levels {ir, camera, radar}
// - i_clr             in   1            1-cycle pulse: clear sticky errors, frame counts and skew
// - i_period_min      in   PER_W        minimum legal period, cycles
// - i_period_max      in   PER_W        maximum legal period, cycles
// - i_width_min       in   WID_W        minimum legal high width
// - i_width_max       in   WID_W        maximum legal high width
// - i_timeout         in   PER_W        no rising edge for this many cycles => channel lost
// - o_period          out  NUM_CH*PER_W last completed period per channel
// - o_width           out  NUM_CH*WID_W last completed high width per channel
// - o_frame_cnt       out  NUM_CH*16    rising edges seen, wraps at 16'hFFFF -> 0
// - o_err_period      out  NUM_CH       sticky: a completed period fell outside [min,max]
// - o_err_width       out  NUM_CH       sticky: a completed width fell outside [min,max]
// - o_lost            out  NUM_CH       sticky: timeout expired while ARMED
// - o_skew            out  PER_W        cycles from ch0 rise to the next ch1 rise
// - o_skew_valid      out  1            1-cycle strobe when o_skew updates
// BEHAVIOUR
// - Reset: every output is 0. Channel FSMs go to IDLE and all counters are 0.
// - Edge detect: register i_fs once; rise = i_fs & ~fs_d1 and fall = ~i_fs & fs_d1. No synchroniser (same domain).
// - Per-channel FSM states: IDLE, HIGH, LOW.
//   - IDLE -> HIGH on rise: per_cnt <= 1, wid_cnt <= 1, frame_cnt++. No period is reported on this first edge.
//   - HIGH: wid_cnt++ and per_cnt++ each cycle.
//   - HIGH -> LOW on fall: o_width <= wid_cnt. Set err_width if wid_cnt < i_width_min or > i_width_max.
//   - LOW: per_cnt++ each cycle.
//   - LOW -> HIGH on rise: o_period <= per_cnt. Check per_cnt against [i_period_min, i_period_max] and set err_period if outside.
//     Restart per_cnt and wid_cnt at 1 and increment frame_cnt.
//   - HIGH/LOW -> IDLE when per_cnt == i_timeout and no rise occurs that cycle: set lost. o_period and o_width hold.
//     The next rise re-arms the channel without reporting a period.
// - Latency: o_period, o_width and error flags update on the clk edge after the registered edge (2 cycles after the input transition).
// - Saturation: per_cnt and wid_cnt stop at all-ones. A saturated width is reported as all-ones and fails width_max.
// - A 1-cycle pulse (rise then fall next cycle) gives width 1. A pulse that is still high at the next rise cannot occur, because rise requires low first.
// - Skew: a ch0 rise starts skew_cnt at 0 (or restarts it if already running).
//   - A ch1 rise while running stops the counter: o_skew <= skew_cnt, pulse o_skew_valid.
//   - ch0 and ch1 rising in the same cycle gives o_skew = 0 and o_skew_valid.
//   - A ch1 rise with no ch0 armed is ignored. skew_cnt saturates and stays running until a ch1 rise or i_clr.
// - i_clr: clears err_period, err_width, lost, frame_cnt, o_skew and the skew run state.
//   - Measurement FSMs are unaffected.
//   - If an error condition and i_clr happen in the same cycle, the error wins: flag = 1 after that cycle.
//   - If a rise and i_clr happen in the same cycle, frame_cnt = 1.
// - Config inputs are sampled every cycle. Changing them mid-frame affects only checks completed afterwards.
// - If rst_n is asserted mid-frame, everything returns to the reset state immediately. Measurement resumes from IDLE.
// STRUCTURE
// - Package framestart_mon_pkg holds:
//   - typedef enum logic [1:0] {IDLE, HIGH, LOW} fs_mon_state_t
//   - localparams CH_RADAR=0, CH_CAMERA=1, CH_IR=2
// - Sub-module fs_chan_meas: one channel's edge detect, FSM, counters and checks. Instanced NUM_CH times with generate.
// - The top level holds the skew counter and the output packing.
// TESTING
// - Periodic pulses: ch0 with period 1000 and width 300, window [900,1100]/[200,400].
//   Expect o_period = 1000, o_width = 300 from the 2nd frame on, no errors, frame_cnt increments each frame.
// - Period 1200 with max 1100: expect err_period[0] = 1 after the 2nd rise, still 1 after later good frames.
//   i_clr then gives 0.
// - Skew: ch1 rises 25 cycles after ch0 -> o_skew = 25 with a single o_skew_valid. Coincident rises -> o_skew = 0.
// - Timeout 5000: stop ch2 after 3 frames -> lost[2] = 1 about 5000 cycles after the last rise.
//   Restarting pulses gives no period report on the first new edge and a correct period on the second.
// - Width of 1 cycle -> o_width = 1 and err_width set (min 200).
//   Error condition in the same cycle as i_clr -> flag reads 1.
// - Assert rst_n mid-HIGH: all outputs 0. After release, the first rise gives frame_cnt = 1 and no period.

Source files
------------

// File: rtl/framestart_monitor_pkg.sv
// Shared types for the framestart monitor.
// Channel FSM encoding and channel index assignments.
package framestart_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } fs_mon_state_t;

    localparam int CH_RADAR  = 0;
    localparam int CH_CAMERA = 1;
    localparam int CH_IR     = 2;

endpackage

// File: rtl/framestart_monitor_if.sv
// Framestart inputs, check windows and status registers as one bundle.
// master drives stimulus/config, slave is the monitor.
interface framestart_monitor_if #(
    parameter int NUM_CH = 3,
    parameter int PER_W  = 32,
    parameter int WID_W  = 16
);
    logic [NUM_CH-1:0]       i_fs;
    logic                    i_clr;
    logic [PER_W-1:0]        i_period_min;
    logic [PER_W-1:0]        i_period_max;
    logic [WID_W-1:0]        i_width_min;
    logic [WID_W-1:0]        i_width_max;
    logic [PER_W-1:0]        i_timeout;
    logic [NUM_CH*PER_W-1:0] o_period;
    logic [NUM_CH*WID_W-1:0] o_width;
    logic [NUM_CH*16-1:0]    o_frame_cnt;
    logic [NUM_CH-1:0]       o_err_period;
    logic [NUM_CH-1:0]       o_err_width;
    logic [NUM_CH-1:0]       o_lost;
    logic [PER_W-1:0]        o_skew;
    logic                    o_skew_valid;

    modport master (
        output i_fs, i_clr,
        output i_period_min, i_period_max,
        output i_width_min, i_width_max,
        output i_timeout,
        input  o_period, o_width, o_frame_cnt,
        input  o_err_period, o_err_width, o_lost,
        input  o_skew, o_skew_valid
    );

    modport slave (
        input  i_fs, i_clr,
        input  i_period_min, i_period_max,
        input  i_width_min, i_width_max,
        input  i_timeout,
        output o_period, o_width, o_frame_cnt,
        output o_err_period, o_err_width, o_lost,
        output o_skew, o_skew_valid
    );

endinterface

// File: rtl/fs_chan_meas.sv
// One framestart channel: edge detect, period/width measurement,
// window checks, loss-of-signal timeout and frame counting.
module fs_chan_meas
    import framestart_mon_pkg::*;
#(
    parameter int PER_W = 32,
    parameter int WID_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fs,
    input  logic             clr,
    input  logic [PER_W-1:0] period_min,
    input  logic [PER_W-1:0] period_max,
    input  logic [WID_W-1:0] width_min,
    input  logic [WID_W-1:0] width_max,
    input  logic [PER_W-1:0] timeout,
    output logic             rise,
    output logic [PER_W-1:0] period,
    output logic [WID_W-1:0] width,
    output logic [15:0]      frame_cnt,
    output logic             err_period,
    output logic             err_width,
    output logic             lost
);

    fs_mon_state_t    state;
    logic             fs_q;
    logic             fs_d1;
    logic             fall;
    logic [PER_W-1:0] per_cnt;
    logic [WID_W-1:0] wid_cnt;
    logic [PER_W-1:0] per_inc;
    logic [WID_W-1:0] wid_inc;
    logic             per_bad;
    logic             wid_bad;
    logic             tmo;

    // fs_q is the input capture flop; edges come from fs_q vs fs_d1
    assign rise = fs_q & ~fs_d1;
    assign fall = ~fs_q & fs_d1;

    assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + PER_W'(1);
    assign wid_inc = (wid_cnt == '1) ? wid_cnt : wid_cnt + WID_W'(1);

    assign per_bad = (per_cnt < period_min) || (per_cnt > period_max);
    assign wid_bad = (wid_cnt < width_min) || (wid_cnt > width_max);

    // a rise in the timeout cycle still counts as a live edge
    assign tmo = (state != IDLE) && (per_cnt == timeout) && !rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fs_q       <= 1'b0;
            fs_d1      <= 1'b0;
            per_cnt    <= '0;
            wid_cnt    <= '0;
            period     <= '0;
            width      <= '0;
            frame_cnt  <= '0;
            err_period <= 1'b0;
            err_width  <= 1'b0;
            lost       <= 1'b0;
        end else begin
            fs_q  <= fs;
            fs_d1 <= fs_q;

            if (rise) begin
                frame_cnt <= clr ? 16'd1 : frame_cnt + 16'd1;
            end else if (clr) begin
                frame_cnt <= '0;
            end

            // new errors take priority over a coincident clear
            err_period <= (err_period & ~clr)
                        | (rise && state == LOW && per_bad);
            err_width  <= (err_width & ~clr)
                        | (fall && state == HIGH && !tmo && wid_bad);
            lost       <= (lost & ~clr) | tmo;

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= HIGH;
                        per_cnt <= PER_W'(1);
                        wid_cnt <= WID_W'(1);
                    end
                end
                HIGH: begin
                    if (tmo) begin
                        state <= IDLE;
                    end else if (fall) begin
                        state   <= LOW;
                        width   <= wid_cnt;
                        per_cnt <= per_inc;
                    end else begin
                        per_cnt <= per_inc;
                        wid_cnt <= wid_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state   <= HIGH;
                        period  <= per_cnt;
                        per_cnt <= PER_W'(1);
                        wid_cnt <= WID_W'(1);
                    end else if (tmo) begin
                        state <= IDLE;
                    end else begin
                        per_cnt <= per_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/framestart_monitor.sv
// Framestart monitor top: per-channel measurement, radar-to-camera
// skew counter and packing of the status registers.
module framestart_monitor
    import framestart_mon_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PER_W  = 32,
    parameter int WID_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    framestart_monitor_if.slave bus
);

    logic [NUM_CH-1:0]       rise;
    logic [NUM_CH*PER_W-1:0] period_flat;
    logic [NUM_CH*WID_W-1:0] width_flat;
    logic [NUM_CH*16-1:0]    frame_flat;
    logic [NUM_CH-1:0]       err_per;
    logic [NUM_CH-1:0]       err_wid;
    logic [NUM_CH-1:0]       lost;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fs_chan_meas #(
            .PER_W (PER_W),
            .WID_W (WID_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .fs         (bus.i_fs[g]),
            .clr        (bus.i_clr),
            .period_min (bus.i_period_min),
            .period_max (bus.i_period_max),
            .width_min  (bus.i_width_min),
            .width_max  (bus.i_width_max),
            .timeout    (bus.i_timeout),
            .rise       (rise[g]),
            .period     (period_flat[g*PER_W +: PER_W]),
            .width      (width_flat[g*WID_W +: WID_W]),
            .frame_cnt  (frame_flat[g*16 +: 16]),
            .err_period (err_per[g]),
            .err_width  (err_wid[g]),
            .lost       (lost[g])
        );
    end

    assign bus.o_period     = period_flat;
    assign bus.o_width      = width_flat;
    assign bus.o_frame_cnt  = frame_flat;
    assign bus.o_err_period = err_per;
    assign bus.o_err_width  = err_wid;
    assign bus.o_lost       = lost;

    logic             skew_run;
    logic [PER_W-1:0] skew_cnt;
    logic             r_radar;
    logic             r_cam;

    assign r_radar = rise[CH_RADAR];
    assign r_cam   = rise[CH_CAMERA];

    // skew_cnt holds the cycles elapsed since the radar rise, so a
    // camera rise N cycles later reads N and a coincident one reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_run         <= 1'b0;
            skew_cnt         <= '0;
            bus.o_skew       <= '0;
            bus.o_skew_valid <= 1'b0;
        end else begin
            bus.o_skew_valid <= 1'b0;
            if (bus.i_clr) begin
                bus.o_skew <= '0;
            end
            if (r_radar && r_cam) begin
                skew_run         <= 1'b0;
                skew_cnt         <= '0;
                bus.o_skew       <= '0;
                bus.o_skew_valid <= 1'b1;
            end else if (r_radar) begin
                skew_run <= 1'b1;
                skew_cnt <= PER_W'(1);
            end else if (bus.i_clr) begin
                skew_run <= 1'b0;
                skew_cnt <= '0;
            end else if (r_cam && skew_run) begin
                skew_run         <= 1'b0;
                bus.o_skew       <= skew_cnt;
                bus.o_skew_valid <= 1'b1;
            end else if (skew_run && skew_cnt != '1) begin
                skew_cnt <= skew_cnt + PER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_framestart_monitor.sv
// Directed self-checking bench for framestart_monitor.
module tb_framestart_monitor;
    import framestart_mon_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    framestart_monitor_if #(
        .NUM_CH (3),
        .PER_W  (32),
        .WID_W  (16)
    ) bus ();

    framestart_monitor #(
        .NUM_CH (3),
        .PER_W  (32),
        .WID_W  (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic pulse(input int ch, input int w, input int p);
        bus.i_fs[ch] = 1'b1;
        tick(w);
        bus.i_fs[ch] = 1'b0;
        tick(p - w);
    endtask

    task automatic clr_pulse();
        bus.i_clr = 1'b1;
        tick(1);
        bus.i_clr = 1'b0;
        tick(1);
    endtask

    function automatic logic [31:0] per(input int ch);
        return bus.o_period[32*ch +: 32];
    endfunction

    function automatic logic [31:0] wid(input int ch);
        return 32'(bus.o_width[16*ch +: 16]);
    endfunction

    function automatic logic [31:0] frm(input int ch);
        return 32'(bus.o_frame_cnt[16*ch +: 16]);
    endfunction

    initial begin
        int vc;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.i_fs         = '0;
        bus.i_clr        = 1'b0;
        bus.i_period_min = 32'd900;
        bus.i_period_max = 32'd1100;
        bus.i_width_min  = 16'd200;
        bus.i_width_max  = 16'd400;
        bus.i_timeout    = 32'd5000;
        tick(3);

        chk("rst_period", 32'(bus.o_period != 0), 0);
        chk("rst_width", 32'(bus.o_width != 0), 0);
        chk("rst_frame", 32'(bus.o_frame_cnt != 0), 0);
        chk("rst_errp", 32'(bus.o_err_period), 0);
        chk("rst_errw", 32'(bus.o_err_width), 0);
        chk("rst_lost", 32'(bus.o_lost), 0);
        chk("rst_skew", bus.o_skew, 0);
        chk("rst_skv", 32'(bus.o_skew_valid), 0);
        rst_n = 1'b1;
        tick(5);

        pulse(CH_RADAR, 300, 1000);
        chk("p1_frame", frm(0), 1);
        chk("p1_noper", per(0), 0);
        chk("p1_width", wid(0), 300);
        pulse(CH_RADAR, 300, 1000);
        pulse(CH_RADAR, 300, 1000);
        chk("p3_frame", frm(0), 3);
        chk("p3_period", per(0), 1000);
        chk("p3_width", wid(0), 300);
        chk("p3_errp", 32'(bus.o_err_period[0]), 0);
        chk("p3_errw", 32'(bus.o_err_width[0]), 0);

        pulse(CH_RADAR, 300, 1200);
        pulse(CH_RADAR, 300, 1000);
        chk("long_period", per(0), 1200);
        chk("long_errp", 32'(bus.o_err_period[0]), 1);
        pulse(CH_RADAR, 300, 1000);
        chk("good_period", per(0), 1000);
        chk("sticky_errp", 32'(bus.o_err_period[0]), 1);
        chk("pre_clr_frame", frm(0), 6);
        clr_pulse();
        chk("clr_errp", 32'(bus.o_err_period[0]), 0);
        chk("clr_frame", frm(0), 0);

        bus.i_fs[CH_RADAR] = 1'b1;
        tick(25);
        bus.i_fs[CH_CAMERA] = 1'b1;
        vc = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vc += int'(bus.o_skew_valid);
        end
        chk("skew25_val", 32'(vc), 1);
        chk("skew25", bus.o_skew, 25);
        bus.i_fs[CH_CAMERA] = 1'b0;
        tick(10);
        bus.i_fs[CH_CAMERA] = 1'b1;
        vc = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vc += int'(bus.o_skew_valid);
        end
        chk("cam_only_val", 32'(vc), 0);
        chk("cam_only_skew", bus.o_skew, 25);
        bus.i_fs = '0;
        tick(20);
        bus.i_fs[CH_RADAR]  = 1'b1;
        bus.i_fs[CH_CAMERA] = 1'b1;
        vc = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vc += int'(bus.o_skew_valid);
        end
        chk("coinc_val", 32'(vc), 1);
        chk("coinc_skew", bus.o_skew, 0);
        bus.i_fs = '0;
        tick(20);
        bus.i_fs[CH_RADAR] = 1'b1;
        tick(7);
        bus.i_fs[CH_CAMERA] = 1'b1;
        tick(5);
        chk("skew7", bus.o_skew, 7);
        bus.i_fs = '0;
        tick(5);
        clr_pulse();
        chk("clr_skew", bus.o_skew, 0);

        pulse(CH_IR, 300, 1000);
        pulse(CH_IR, 300, 1000);
        pulse(CH_IR, 300, 1000);
        chk("ir_frame", frm(2), 3);
        tick(3990);
        chk("ir_not_lost", 32'(bus.o_lost[2]), 0);
        tick(20);
        chk("ir_lost", 32'(bus.o_lost[2]), 1);
        chk("ir_hold_per", per(2), 1000);
        chk("ir_hold_wid", wid(2), 300);
        pulse(CH_IR, 300, 950);
        chk("ir_rearm_per", per(2), 1000);
        chk("ir_rearm_frm", frm(2), 4);
        pulse(CH_IR, 300, 950);
        chk("ir_new_per", per(2), 950);
        chk("ir_new_errp", 32'(bus.o_err_period[2]), 0);
        chk("ir_lost_stk", 32'(bus.o_lost[2]), 1);

        clr_pulse();
        chk("cam_errw_clr", 32'(bus.o_err_width[1]), 0);
        bus.i_fs[CH_CAMERA] = 1'b1;
        tick(1);
        bus.i_fs[CH_CAMERA] = 1'b0;
        tick(10);
        chk("w1_width", wid(1), 1);
        chk("w1_errw", 32'(bus.o_err_width[1]), 1);
        clr_pulse();
        chk("w1_clr", 32'(bus.o_err_width[1]), 0);
        bus.i_fs[CH_CAMERA] = 1'b1;
        tick(1);
        bus.i_fs[CH_CAMERA] = 1'b0;
        tick(1);
        bus.i_clr = 1'b1;
        tick(1);
        bus.i_clr = 1'b0;
        tick(3);
        chk("err_beats_clr", 32'(bus.o_err_width[1]), 1);
        chk("clr_frame_c", frm(1), 0);
        bus.i_fs[CH_CAMERA] = 1'b1;
        tick(2);
        bus.i_fs[CH_CAMERA] = 1'b0;
        tick(5);
        chk("cam_frame1", frm(1), 1);
        bus.i_fs[CH_CAMERA] = 1'b1;
        tick(1);
        bus.i_clr = 1'b1;
        tick(1);
        bus.i_clr = 1'b0;
        bus.i_fs[CH_CAMERA] = 1'b0;
        tick(3);
        chk("rise_clr_frm", frm(1), 1);

        bus.i_fs[CH_RADAR] = 1'b1;
        tick(50);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_per", 32'(bus.o_period != 0), 0);
        chk("mid_rst_wid", 32'(bus.o_width != 0), 0);
        chk("mid_rst_frm", 32'(bus.o_frame_cnt != 0), 0);
        chk("mid_rst_err", 32'({bus.o_err_period, bus.o_err_width}), 0);
        chk("mid_rst_lost", 32'(bus.o_lost), 0);
        bus.i_fs = '0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        pulse(CH_RADAR, 300, 1000);
        chk("post_rst_frm", frm(0), 1);
        chk("post_rst_per", per(0), 0);
        chk("post_rst_wid", wid(0), 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
